// File: rtl/stepper_pkg.sv
// Shared definitions for the step/dir pulse generator: FSM states, register map, CTRL bits.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_LOW
  } step_state_t;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STEPS  = 2'd1,
    REG_PERIOD = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_t;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_DIR   = 1;
  localparam int unsigned CTRL_ABORT = 2;

endpackage

// File: rtl/step_bus_slave.sv
// Bus side of one stepper axis: one-shot ready handshake, tristated read data, STEPS/PERIOD/dir registers.
module step_bus_slave
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic                 enable,
  input  logic                 write,
  input  logic [1:0]           addr_in,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 ready,
  input  logic [CNT_WIDTH-1:0] remaining,
  input  logic                 busy,
  output logic                 start,
  output logic                 abort,
  output logic                 start_dir,
  output logic [CNT_WIDTH-1:0] steps,
  output logic [CNT_WIDTH-1:0] period
);

  logic                 r_ready;
  logic                 r_done;
  logic [31:0]          r_rdata;
  logic                 r_dir;
  logic [CNT_WIDTH-1:0] r_steps;
  logic [CNT_WIDTH-1:0] r_period;
  logic [31:0]          rd_mux;
  logic                 wr_ctrl;
  logic                 unused_bits;

  assign unused_bits = ^data_in[31:CNT_WIDTH];

  assign data_out = enable ? r_rdata : 'z;
  assign ready    = enable ? r_ready : 1'bz;

  // Start and abort are strobes valid only on the ready cycle of a CTRL store; abort masks start.
  assign wr_ctrl   = r_ready && enable && write && (addr_in == REG_CTRL);
  assign start     = wr_ctrl && data_in[CTRL_START] && !data_in[CTRL_ABORT];
  assign abort     = wr_ctrl && data_in[CTRL_ABORT];
  assign start_dir = data_in[CTRL_DIR];

  assign steps  = r_steps;
  assign period = r_period;

  always_comb begin
    rd_mux = '0;
    case (addr_in)
      REG_CTRL:   rd_mux = {30'b0, r_dir, 1'b0};
      REG_STEPS:  rd_mux = 32'(r_steps);
      REG_PERIOD: rd_mux = 32'(r_period);
      REG_STATUS: rd_mux = (32'(remaining) << 8) | 32'(busy);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_dir    <= 1'b0;
      r_steps  <= '0;
      r_period <= '0;
    end else begin
      if (!enable) begin
        r_ready <= 1'b0;
        r_done  <= 1'b0;
      end else if (!r_done) begin
        r_ready <= 1'b1;
        r_done  <= 1'b1;
        r_rdata <= rd_mux;
      end else begin
        r_ready <= 1'b0;
      end

      if (r_ready && enable && write) begin
        case (addr_in)
          REG_CTRL:   r_dir    <= data_in[CTRL_DIR];
          REG_STEPS:  r_steps  <= data_in[CNT_WIDTH-1:0];
          REG_PERIOD: r_period <= data_in[CNT_WIDTH-1:0];
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: rtl/step_generator.sv
// One stepper axis: memory-mapped registers plus the step/dir FSM that emits timed step pulses.
module step_generator
  import stepper_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned PULSE_WIDTH = 25,
  parameter int unsigned DIR_SETUP   = 5
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable,
  input  logic        write,
  input  logic [1:0]  addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        step_out,
  output logic        dir_out,
  output logic        r_busy_out
);

  localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(PULSE_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] SETUP_LAST = CNT_WIDTH'(DIR_SETUP - 1);

  step_state_t          state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [CNT_WIDTH-1:0] r_low_last;
  logic                 r_abort_pend;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] eff_period;
  logic                 start;
  logic                 abort;
  logic                 start_dir;
  logic [CNT_WIDTH-1:0] steps;
  logic [CNT_WIDTH-1:0] period;

  step_bus_slave #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_bus (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .enable    (enable),
    .write     (write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .ready     (ready),
    .remaining (r_remaining),
    .busy      (r_busy_out),
    .start     (start),
    .abort     (abort),
    .start_dir (start_dir),
    .steps     (steps),
    .period    (period)
  );

  assign cnt_next   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign eff_period = (period < MIN_PERIOD) ? MIN_PERIOD : period;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state        <= ST_IDLE;
      r_cnt        <= '0;
      r_remaining  <= '0;
      r_low_last   <= '0;
      r_abort_pend <= 1'b0;
      step_out     <= 1'b0;
      dir_out      <= 1'b0;
      r_busy_out   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && steps != '0) begin
            state        <= ST_SETUP;
            r_cnt        <= '0;
            r_remaining  <= steps;
            // low phase length is eff_period - PULSE_WIDTH, stored as its last count
            r_low_last   <= eff_period - MIN_PERIOD;
            r_abort_pend <= 1'b0;
            dir_out      <= start_dir;
            r_busy_out   <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (abort) begin
            state      <= ST_IDLE;
            r_busy_out <= 1'b0;
          end else if (r_cnt == SETUP_LAST) begin
            state    <= ST_PULSE;
            step_out <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= cnt_next;
          end
        end

        ST_PULSE: begin
          if (abort) r_abort_pend <= 1'b1;
          if (r_cnt == PULSE_LAST) begin
            step_out <= 1'b0;
            r_cnt    <= '0;
            if (r_remaining != '0) r_remaining <= r_remaining - 1'b1;
            if (abort || r_abort_pend) begin
              state      <= ST_IDLE;
              r_busy_out <= 1'b0;
            end else begin
              state <= ST_LOW;
            end
          end else begin
            r_cnt <= cnt_next;
          end
        end

        ST_LOW: begin
          if (abort) begin
            state      <= ST_IDLE;
            r_busy_out <= 1'b0;
          end else if (r_cnt == r_low_last) begin
            r_cnt <= '0;
            if (r_remaining != '0) begin
              state    <= ST_PULSE;
              step_out <= 1'b1;
            end else begin
              state      <= ST_IDLE;
              r_busy_out <= 1'b0;
            end
          end else begin
            r_cnt <= cnt_next;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_generator.sv
// Scenario bench for step_generator: bus accesses drive moves, a pulse monitor checks against expected pulses.
module tb_step_generator;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STEPS  = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef struct {
    int   rise;
    int   width;
    logic dir;
  } pulse_t;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  wire  [31:0] data_out;
  wire         ready;
  logic        step_out;
  logic        dir_out;
  logic        r_busy_out;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     last_ready = 0;
  bit     mon_en = 1'b0;
  pulse_t exp_q[$];

  step_generator #(
    .CNT_WIDTH  (24),
    .PULSE_WIDTH(25),
    .DIR_SETUP  (5)
  ) dut (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .enable    (enable),
    .write     (write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .ready     (ready),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .r_busy_out(r_busy_out)
  );

  always #20 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Pulse monitor: every completed step pulse is popped against the expected queue.
  initial begin
    logic   prev;
    int     rise;
    logic   rdir;
    pulse_t e;
    prev = 1'b0;
    rise = 0;
    rdir = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (mon_en) begin
        if (step_out && !prev) begin
          rise = cyc;
          rdir = dir_out;
        end
        if (!step_out && prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: pulse rising at cycle %0d, expected no pulse", rise);
          end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (rise !== e.rise) $display("FAIL pulse_rise: got cycle %0d, expected %0d", rise, e.rise);
            else n_pass++;
            n_checks++;
            if ((cyc - rise) !== e.width) $display("FAIL pulse_width: got %0d, expected %0d", cyc - rise, e.width);
            else n_pass++;
            n_checks++;
            if (rdir !== e.dir) $display("FAIL pulse_dir: got %0b, expected %0b", rdir, e.dir);
            else n_pass++;
          end
        end
        prev = step_out;
      end else begin
        prev = 1'b0;
      end
    end
  end

  initial begin
    #(40 * 30000);
    $display("FAIL watchdog: simulation exceeded 30000 cycles");
    $fatal(1);
  end

  task automatic bus_access(input logic wr, input logic [1:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
    int found;
    found = -1;
    rd = '0;
    @(posedge clk_in);
    #1;
    enable  = 1'b1;
    write   = wr;
    addr_in = a;
    data_in = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in);
      #1;
      if (ready === 1'b1) begin
        found = i;
        rd = data_out;
        last_ready = cyc;
        break;
      end
    end
    n_checks++;
    if (found !== 0) $display("FAIL ready_latency: got ready after %0d cycles, expected 1", found + 1);
    else n_pass++;
    @(posedge clk_in);
    #1;
    n_checks++;
    if (ready !== 1'b0) $display("FAIL ready_oneshot: got ready=%0b in second cycle, expected 0", ready);
    else n_pass++;
    enable = 1'b0;
    write  = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_access(1'b1, a, d, dummy);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    bus_access(1'b0, a, '0, d);
  endtask

  task automatic push_moves(input int first, input int per, input int count, input logic d);
    pulse_t p;
    for (int k = 0; k < count; k++) begin
      p.rise  = first + k * per;
      p.width = 25;
      p.dir   = d;
      exp_q.push_back(p);
    end
  endtask

  task automatic wait_idle(input int budget, output int drop);
    drop = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_in);
      #1;
      if (r_busy_out === 1'b0) begin
        drop = cyc;
        break;
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++;
    if ({step_out, dir_out, r_busy_out} !== 3'b000)
      $display("FAIL reset_outputs: got step/dir/busy=%b, expected 000", {step_out, dir_out, r_busy_out});
    else n_pass++;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    mon_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), rd);
      n_checks++;
      if (rd !== 32'h0) $display("FAIL reset_reg%0d: got %h, expected 00000000", a, rd);
      else n_pass++;
    end
  endtask

  task automatic test_basic_move;
    int rc;
    int drop;
    wr_reg(A_STEPS, 32'd3);
    wr_reg(A_PERIOD, 32'd100);
    wr_reg(A_CTRL, 32'h3);
    rc = last_ready;
    push_moves(rc + 6, 100, 3, 1'b1);
    n_checks++;
    if ({dir_out, r_busy_out} !== 2'b11) $display("FAIL basic_start: got dir/busy=%b, expected 11", {dir_out, r_busy_out});
    else n_pass++;
    wait_idle(1000, drop);
    n_checks++;
    if (drop !== rc + 306) $display("FAIL basic_busy_drop: got cycle %0d, expected %0d", drop, rc + 306);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL basic_missing: got %0d pulses outstanding, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_min_period;
    int rc;
    int drop;
    logic [31:0] rd;
    wr_reg(A_PERIOD, 32'd10);
    wr_reg(A_STEPS, 32'd2);
    wr_reg(A_CTRL, 32'h1);
    rc = last_ready;
    push_moves(rc + 6, 26, 2, 1'b0);
    rd_reg(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h201) $display("FAIL status_rem2: got %h, expected 00000201", rd);
    else n_pass++;
    wait_until(rc + 40);
    rd_reg(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h101) $display("FAIL status_rem1: got %h, expected 00000101", rd);
    else n_pass++;
    wait_idle(500, drop);
    n_checks++;
    if (drop !== rc + 58) $display("FAIL minper_busy_drop: got cycle %0d, expected %0d", drop, rc + 58);
    else n_pass++;
    rd_reg(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL status_rem0: got %h, expected 00000000", rd);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL minper_missing: got %0d pulses outstanding, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_abort;
    int rc;
    int drop;
    logic [31:0] rd;
    wr_reg(A_PERIOD, 32'd100);
    wr_reg(A_STEPS, 32'd3);
    wr_reg(A_CTRL, 32'h1);
    rc = last_ready;
    push_moves(rc + 6, 100, 1, 1'b0);
    wait_until(rc + 7);
    wr_reg(A_CTRL, 32'h4);
    wait_idle(500, drop);
    n_checks++;
    if (drop !== rc + 31) $display("FAIL abort_busy_drop: got cycle %0d, expected %0d", drop, rc + 31);
    else n_pass++;
    rd_reg(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h200) $display("FAIL abort_remaining: got %h, expected 00000200", rd);
    else n_pass++;
    repeat (150) @(posedge clk_in);
    #1;
    n_checks++;
    if (r_busy_out !== 1'b0 || exp_q.size() !== 0)
      $display("FAIL abort_quiet: got busy=%0b outstanding=%0d, expected 0/0", r_busy_out, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_no_move;
    int rc;
    int drop;
    logic [31:0] rd;
    wr_reg(A_STEPS, 32'd0);
    wr_reg(A_CTRL, 32'h1);
    repeat (20) @(posedge clk_in);
    #1;
    n_checks++;
    if (r_busy_out !== 1'b0) $display("FAIL zero_steps_busy: got %0b, expected 0", r_busy_out);
    else n_pass++;
    wr_reg(A_STEPS, 32'd5);
    wr_reg(A_CTRL, 32'h5);
    repeat (20) @(posedge clk_in);
    #1;
    n_checks++;
    if (r_busy_out !== 1'b0) $display("FAIL start_abort_busy: got %0b, expected 0", r_busy_out);
    else n_pass++;
    wr_reg(A_PERIOD, 32'd100);
    wr_reg(A_STEPS, 32'd1);
    wr_reg(A_CTRL, 32'h1);
    rc = last_ready;
    push_moves(rc + 6, 100, 1, 1'b0);
    wr_reg(A_CTRL, 32'h3);
    n_checks++;
    if (dir_out !== 1'b0) $display("FAIL restart_dir: got %0b, expected 0", dir_out);
    else n_pass++;
    wait_idle(500, drop);
    n_checks++;
    if (drop !== rc + 106) $display("FAIL restart_busy_drop: got cycle %0d, expected %0d", drop, rc + 106);
    else n_pass++;
    repeat (20) @(posedge clk_in);
    rd_reg(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h2) $display("FAIL ctrl_readback: got %h, expected 00000002", rd);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL restart_missing: got %0d pulses outstanding, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int rc;
    int drop;
    logic [31:0] rd;
    wr_reg(A_PERIOD, 32'd30);
    wr_reg(A_STEPS, 32'd4);
    wr_reg(A_CTRL, 32'h3);
    rc = last_ready;
    push_moves(rc + 6, 30, 4, 1'b1);
    wr_reg(A_STEPS, 32'd9);
    wr_reg(A_CTRL, 32'h0);
    n_checks++;
    if (dir_out !== 1'b1) $display("FAIL b2b_old_dir: got %0b, expected 1", dir_out);
    else n_pass++;
    wait_idle(1000, drop);
    n_checks++;
    if (drop !== rc + 126) $display("FAIL b2b_first_drop: got cycle %0d, expected %0d", drop, rc + 126);
    else n_pass++;
    rd_reg(A_STEPS, rd);
    n_checks++;
    if (rd !== 32'd9) $display("FAIL b2b_steps_reg: got %h, expected 00000009", rd);
    else n_pass++;
    wr_reg(A_CTRL, 32'h1);
    rc = last_ready;
    push_moves(rc + 6, 30, 9, 1'b0);
    n_checks++;
    if (dir_out !== 1'b0) $display("FAIL b2b_new_dir: got %0b, expected 0", dir_out);
    else n_pass++;
    wait_idle(1000, drop);
    n_checks++;
    if (drop !== rc + 276) $display("FAIL b2b_second_drop: got cycle %0d, expected %0d", drop, rc + 276);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL b2b_missing: got %0d pulses outstanding, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_move;
    int rc;
    logic [31:0] rd;
    wr_reg(A_CTRL, 32'h3);
    rc = last_ready;
    wait_until(rc + 10);
    mon_en = 1'b0;
    exp_q.delete();
    reset_n_in = 1'b0;
    #1;
    n_checks++;
    if ({step_out, dir_out, r_busy_out} !== 3'b000)
      $display("FAIL midmove_reset: got step/dir/busy=%b, expected 000", {step_out, dir_out, r_busy_out});
    else n_pass++;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    rd_reg(A_STEPS, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL midmove_steps_reg: got %h, expected 00000000", rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_min_period();
    test_abort();
    test_no_move();
    test_back_to_back();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
